// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks (mod_exp, r2_mod_n_calc and helpers).
package rsa_pkg;

  // Montgomery radix exponent K for a given operand width.
  function automatic int unsigned k_of(input int unsigned width);
    return width + 2;
  endfunction

  // Width of a counter that steps through the 2K double-and-reduce iterations.
  function automatic int unsigned cnt_width_of(input int unsigned width);
    return $clog2(2 * k_of(width));
  endfunction

  typedef enum logic [0:0] {StIdle, StRun} state_e;

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: y = (2x) mod n, valid when x < n.
module mod_double #(
  parameter int unsigned DATA_WIDTH = 65
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] n,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH:0] dbl;
  logic [DATA_WIDTH:0] n_ext;

  assign dbl   = {x, 1'b0};
  assign n_ext = {1'b0, n};

  // With x < n the reduced value is below n, so it always fits in DATA_WIDTH bits.
  assign y = DATA_WIDTH'((dbl >= n_ext) ? (dbl - n_ext) : dbl);

endmodule

// File: rtl/r2_mod_n_calc.sv
// Computes r2_mod_n = 2^(2K) mod n (K = DATA_WIDTH + 2) by 2K double-and-reduce steps.
module r2_mod_n_calc
  import rsa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] r2_mod_n,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned K    = k_of(DATA_WIDTH);
  localparam int unsigned CntW = cnt_width_of(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * K - 1);

  state_e                  state;
  logic [DATA_WIDTH-1:0]   n_r;
  logic [DATA_WIDTH-1:0]   x;
  logic [DATA_WIDTH-1:0]   x_next;
  logic [CntW-1:0]         cnt;

  mod_double #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mod_double (
    .x(x),
    .n(n_r),
    .y(x_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      n_r      <= '0;
      x        <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      r2_mod_n <= '0;
    end else if (ce) begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (n == '0) begin
              // Degenerate modulus: report immediately and stay idle.
              r2_mod_n <= '0;
              err      <= 1'b1;
              done     <= 1'b1;
            end else begin
              n_r   <= n;
              x     <= (n == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
              cnt   <= '0;
              ready <= 1'b0;
              state <= StRun;
            end
          end
        end
        StRun: begin
          x   <= x_next;
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            r2_mod_n <= x_next;
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_r2_mod_n_calc.sv
// Randomized self-checking bench for r2_mod_n_calc against a wide-arithmetic reference model.
module tb_r2_mod_n_calc;

  localparam int unsigned DW = 65;
  localparam int unsigned K  = DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          start;
  logic [DW-1:0] n;
  logic          ready;
  logic [DW-1:0] r2_mod_n;
  logic          done;
  logic          err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] prev_r2;

  r2_mod_n_calc #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .start(start),
    .n(n),
    .ready(ready),
    .r2_mod_n(r2_mod_n),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 2^(2K) mod n as (2^K mod n)^2 mod n using plain wide arithmetic.
  function automatic logic [DW-1:0] model_r2(input logic [DW-1:0] nv);
    logic [139:0] nn;
    logic [139:0] r;
    if (nv == '0) return '0;
    nn = {75'b0, nv};
    r  = (140'b1 << K) % nn;
    r  = (r * r) % nn;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_n();
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    return v[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ce_mode: 0 = always high, 1 = alternate 0/1, 2 = random.
  task automatic run_job(input string tag, input logic [DW-1:0] nv, input int ce_mode,
                         input bit inject, input bit has_exp, input logic [DW-1:0] exp_r2);
    int ce_edges;
    int bad_ready;
    int bad_hold;
    bit seen;
    logic ce_v;
    logic [DW-1:0] model;
    model = model_r2(nv);
    ce    = 1'b1;
    start = 1'b1;
    n     = nv;
    tick();
    start = 1'b0;
    n     = rand_n();
    if (nv == '0) begin
      check_eq({tag, "_zero_done"}, 128'(done), 128'(1));
      check_eq({tag, "_zero_err"}, 128'(err), 128'(1));
      check_eq({tag, "_zero_r2"}, 128'(r2_mod_n), 128'(0));
      check_eq({tag, "_zero_ready"}, 128'(ready), 128'(1));
      prev_r2 = '0;
      return;
    end
    ce_edges  = 1;
    bad_ready = 0;
    bad_hold  = 0;
    seen      = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (ce_mode == 0) ce_v = 1'b1;
      else if (ce_mode == 1) ce_v = i[0];
      else ce_v = 1'($urandom_range(0, 1));
      ce = ce_v;
      if (inject && ce_edges == 20) begin
        start = 1'b1;
        n     = ~nv;
      end else begin
        start = 1'b0;
      end
      tick();
      if (ce_v) ce_edges++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (ready !== 1'b0) bad_ready++;
        if (r2_mod_n !== prev_r2) bad_hold++;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 128'(seen), 128'(1));
    check_eq({tag, "_latency"}, 128'(ce_edges - 1), 128'(2 * K));
    check_eq({tag, "_ready_low_in_run"}, 128'(bad_ready), 128'(0));
    check_eq({tag, "_r2_held_in_run"}, 128'(bad_hold), 128'(0));
    check_eq({tag, "_err"}, 128'(err), 128'(0));
    check_eq({tag, "_ready_at_done"}, 128'(ready), 128'(1));
    check_eq({tag, "_r2_model"}, 128'(r2_mod_n), 128'(model));
    if (has_exp) check_eq({tag, "_r2_vector"}, 128'(r2_mod_n), 128'(exp_r2));
    prev_r2 = model;
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b1;
    start   = 1'b0;
    n       = '0;
    prev_r2 = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_ready", 128'(ready), 128'(1));
    check_eq("reset_done", 128'(done), 128'(0));
    check_eq("reset_err", 128'(err), 128'(0));
    check_eq("reset_r2", 128'(r2_mod_n), 128'(0));

    run_job("all_ones", 65'h1_FFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b1, 65'h10);
    // done holds through ce=0 and drops on the next enabled edge.
    ce = 1'b0;
    tick();
    check_eq("done_hold_ce_low", 128'(done), 128'(1));
    ce = 1'b1;
    tick();
    check_eq("done_drop", 128'(done), 128'(0));
    check_eq("r2_hold_idle", 128'(r2_mod_n), 128'(65'h10));

    // Back-to-back: the second start lands in the done cycle of the first.
    run_job("b2b_a", 65'h1_0101_0101_0101_0101, 0, 1'b0, 1'b1, 65'h4000_0000_0000_0000);
    run_job("b2b_b", 65'h1_1CEB_00DA_1CEB_00DD, 0, 1'b0, 1'b1, 65'hC28D_4955_79D8_30AA);
    tick();

    run_job("ce_toggle", 65'h0_0000_01F1_A1F1_A1F1, 1, 1'b0, 1'b1, 65'h1C0_1054_F7AD);
    tick();
    check_eq("ce_toggle_done_one", 128'(done), 128'(0));

    run_job("n_one", 65'h1, 0, 1'b0, 1'b1, 65'h0);
    tick();
    run_job("n_zero", 65'h0, 0, 1'b0, 1'b0, 65'h0);
    tick();
    check_eq("n_zero_done_drop", 128'(done), 128'(0));
    check_eq("n_zero_err_drop", 128'(err), 128'(0));

    run_job("ignored_start", 65'h1_FFBF_FFAF_FFFF_FCFF, 0, 1'b1, 1'b1,
            65'h1_54B4_7BD7_FA04_9270);
    tick();

    // Reset mid-run, with a start in the reset cycle that must lose.
    ce    = 1'b1;
    start = 1'b1;
    n     = 65'h1_2345_6789_ABCD_EF01;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check_eq("midrun_ready", 128'(ready), 128'(0));
    rst   = 1'b1;
    start = 1'b1;
    n     = '0;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_eq("rst_ready", 128'(ready), 128'(1));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_err", 128'(err), 128'(0));
    check_eq("rst_r2", 128'(r2_mod_n), 128'(0));
    prev_r2 = '0;

    for (int j = 0; j < 8; j++) begin
      logic [DW-1:0] rn;
      rn = rand_n();
      if (j == 3) rn = DW'($urandom_range(2, 1000));
      if (j == 5) rn = {1'b0, rn[DW-2:0]} | DW'(1);
      run_job($sformatf("rand%0d", j), rn, j % 3, j[0], 1'b0, '0);
      if (j[1]) tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
